seq_bla_subtractor: RTL and testbench

- Multi-cycle WIDTH-bit subtractor: computes diff = a − b − bin four bits per clock using a 4-bit borrow-lookahead slice.
- Subtraction-side counterpart to the 4-bit carry-lookahead adder datapath.
- Provides borrow-out and signed-overflow flags behind a start/ready/done handshake.
- Intended for wide arithmetic where a full-width lookahead subtractor is too large.

---
 rtl/seq_bla_pkg.sv | 19 +
 rtl/seq_bla_subtractor_slice.sv | 42 ++++
 rtl/seq_bla_subtractor.sv | 128 ++++++++++++
 tb/tb_seq_bla_subtractor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seq_bla_pkg.sv
// Shared types and constants for the sequential borrow-lookahead subtractor.
package seq_bla_pkg;

    // Width of the borrow-lookahead slice processed each clock
    localparam int SLICE_W = 4;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slices needed to cover an operand of the given width
    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/seq_bla_subtractor_slice.sv
// bla_slice4: combinational 4-bit borrow-lookahead subtractor, d = a - b - bin.
// Internal borrows are written out in flattened generate/propagate form so
// that no borrow depends on another computed borrow.
module bla_slice4
    import seq_bla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_br;

    // Per-bit borrow generate (a=0,b=1) and propagate (a==b)
    always_comb begin
        w_g = ~a & b;
        w_p = ~(a ^ b);
    end

    // Lookahead borrows, each expressed directly from g, p and bin
    always_comb begin
        w_br[0] = bin;
        w_br[1] = w_g[0] | (w_p[0] & bin);
        w_br[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
        w_br[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & bin);
        w_br[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bin);
    end

    // Difference bits and slice borrow-out
    always_comb begin
        d    = a ^ b ^ w_br[3:0];
        bout = w_br[4];
    end

endmodule

// File: rtl/seq_bla_subtractor.sv
// seq_bla_subtractor: WIDTH-bit a - b - bin computed one 4-bit lookahead
// slice per clock, with borrow-out and signed-overflow flags and a
// start/ready/done handshake.
module seq_bla_subtractor
    import seq_bla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = slice_count(WIDTH);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t r_state;
    state_t w_next;

    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic [IW-1:0]    w_base;
    logic [3:0]       w_sd;
    logic             w_sbo;
    logic [WIDTH-1:0] w_merged;
    logic             w_last;

    // Bit offset of the active slice; k*4 always fits in the index width
    always_comb begin
        w_base = IW'({r_k, 2'b00});
        w_last = (r_k == K_LAST);
    end

    // Single slice instance, time-multiplexed across the operand
    bla_slice4 u_slice (
        .a    (r_a[w_base +: SLICE_W]),
        .b    (r_b[w_base +: SLICE_W]),
        .bin  (r_br),
        .d    (w_sd),
        .bout (w_sbo)
    );

    // Work register with the current slice result written in
    always_comb begin
        w_merged = r_work;
        w_merged[w_base +: SLICE_W] = w_sd;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Slice counter and result registers; an abandoned operation leaves zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k    <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_k <= '0;
            end else if (r_state == RUN) begin
                if (w_last) begin
                    r_k    <= '0;
                    r_diff <= w_merged;
                    r_bout <= w_sbo;
                    r_ovf  <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_merged[WIDTH-1] ^ r_a[WIDTH-1]);
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    // Operand capture on acceptance and per-slice work/borrow update
    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) begin
            r_a    <= a;
            r_b    <= b;
            r_br   <= bin;
            r_work <= '0;
        end else if (r_state == RUN) begin
            r_work <= w_merged;
            r_br   <= w_sbo;
        end
    end

    // Handshake and result outputs
    always_comb begin
        ready = (r_state == IDLE);
        done  = (r_state == DONE);
        diff  = r_diff;
        bout  = r_bout;
        ovf   = r_ovf;
    end

endmodule

// File: tb/tb_seq_bla_subtractor.sv
// Directed bench for seq_bla_subtractor at WIDTH=16.
module tb_seq_bla_subtractor;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int n_vec;
    int n_bad;
    int cyc;

    seq_bla_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one operation from IDLE and check latency and results
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tbin, input logic [15:0] ed, input logic eb, input logic eo);
        int cnt;
        int guard;
        guard = 0;
        while (!ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check({tag, " latency"}, cnt, 4);
        check({tag, " diff"}, {16'h0, diff}, {16'h0, ed});
        check({tag, " bout"}, {31'h0, bout}, {31'h0, eb});
        check({tag, " ovf"}, {31'h0, ovf}, {31'h0, eo});
        @(negedge clk);
        check({tag, " ready after done"}, {31'h0, ready}, 32'd1);
    endtask

    initial begin
        int cnt;
        int ndone;
        int t_done [3];
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", {31'h0, ready}, 32'd1);
        check("reset done", {31'h0, done}, 32'd0);
        check("reset diff", {16'h0, diff}, 32'h0);
        check("reset bout", {31'h0, bout}, 32'd0);
        check("reset ovf", {31'h0, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("basic",     16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("zero-one",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("negovf",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("posovf",    16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_op("chain",     16'h0F0F, 16'h0F0F, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("mixed",     16'h5A5A, 16'h1234, 1'b1, 16'h4825, 1'b0, 1'b0);

        // start pulses during RUN must be ignored; diff holds 0x4825 until done
        a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; bin = 1'b1;
        cnt = 0;
        while (!done && cnt < 20) begin
            start = ~start;
            check("ignored-start diff hold", {16'h0, diff}, 32'h4825);
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        check("ignored-start latency", cnt, 4);
        check("ignored-start diff", {16'h0, diff}, 32'h1000);
        check("ignored-start bout", {31'h0, bout}, 32'd0);
        @(negedge clk);
        check("ignored-start ready", {31'h0, ready}, 32'd1);

        // reset during the second RUN cycle abandons the operation
        a = 16'h0000; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst ready", {31'h0, ready}, 32'd1);
        check("midrst done", {31'h0, done}, 32'd0);
        check("midrst diff", {16'h0, diff}, 32'h0);
        check("midrst bout", {31'h0, bout}, 32'd0);
        check("midrst ovf", {31'h0, ovf}, 32'd0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst no done", ndone, 0);

        // start held high: back-to-back operations, done every 6 cycles
        a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
        ndone = 0;
        cnt = 0;
        while (ndone < 3 && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (done) begin
                t_done[ndone] = cyc;
                ndone++;
                check("held diff", {16'h0, diff}, 32'h1000);
            end
        end
        start = 1'b0;
        check("held done count", ndone, 3);
        if (ndone == 3) begin
            check("held spacing 1", t_done[1] - t_done[0], 6);
            check("held spacing 2", t_done[2] - t_done[1], 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
